// File: rtl/ocm_noise_streamer_if.sv
// rtl/ocm_noise_streamer_if.sv - OCM read bus and noise sample stream bundle
//
// Purpose: groups the single-port noise OCM read interface and the downstream
// noise sample valid/ready stream that ocm_noise_streamer drives.
//
// Ports (master = streamer, slave = OCM + noise-injection consumer):
//   ocm_address     ADDR_W       OCM word address
//   ocm_chipselect  1            read issue strobe
//   ocm_write       1            always 0 (read-only master)
//   ocm_byteenable  DATA_W/8     always all-ones
//   ocm_clken       1            OCM clock enable, follows reset
//   ocm_readdata    DATA_W       read data, valid the cycle after issue
//   noise_data      SAMPLE_W     signed noise sample
//   noise_valid     1            sample valid
//   noise_ready     1            consumer ready
interface ocm_noise_streamer_if #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 8
);
  logic [ADDR_W-1:0]   ocm_address;
  logic                ocm_chipselect;
  logic                ocm_write;
  logic [DATA_W/8-1:0] ocm_byteenable;
  logic                ocm_clken;
  logic [DATA_W-1:0]   ocm_readdata;
  logic [SAMPLE_W-1:0] noise_data;
  logic                noise_valid;
  logic                noise_ready;

  modport master (
    output ocm_address, ocm_chipselect, ocm_write, ocm_byteenable, ocm_clken,
    output noise_data, noise_valid,
    input  ocm_readdata, noise_ready
  );

  modport slave (
    input  ocm_address, ocm_chipselect, ocm_write, ocm_byteenable, ocm_clken,
    input  noise_data, noise_valid,
    output ocm_readdata, noise_ready
  );
endinterface

// File: rtl/ocm_noise_streamer.sv
// rtl/ocm_noise_streamer.sv - cyclic OCM read master with noise sample unpacker
//
// Purpose: sweeps the noise OCM table cyclically, prefetches words into a small
// FIFO and emits each word as LANES signed samples, lane 0 first, one per cycle.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   enable      1 = stream, 0 = stop issuing and drain buffered words
//   num_words   table length latched on IDLE->RUN, 0 means 2**ADDR_W
//   wrap_pulse  high in the cycle the last table word is issued
//   busy        high while RUN or DRAIN
//   bus         OCM read bus and noise stream (master side)
module ocm_noise_streamer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] num_words,
  output logic              wrap_pulse,
  output logic              busy,
  ocm_noise_streamer_if.master bus
);

  localparam int LANES = DATA_W / SAMPLE_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] nw_q;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;

  // Remaining lanes of the current word; lane 0 of it is always noise_data.
  logic [DATA_W-1:0] shift_q;
  logic [LW-1:0]     lane_q;
  logic              hold_q;

  logic              issue;
  logic              fire, last_lane, need_word, load, pop, push, drained;
  logic [DATA_W-1:0] load_word;
  logic [CW:0]       occupancy;
  logic              room;
  logic [ADDR_W-1:0] last_addr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // num_words==0 underflows to all-ones, i.e. the full 2**ADDR_W table.
  assign last_addr = nw_q - ADDR_W'(1);

  assign fire      = hold_q & bus.noise_ready;
  assign last_lane = (lane_q == LW'(LANES - 1));
  assign need_word = ~hold_q | (fire & last_lane);
  assign load      = need_word & ((count_q != '0) | inflight_q);
  assign pop       = load & (count_q != '0);
  // With the FIFO empty the returning word goes straight into the unpacker,
  // which is what gives the three-cycle first-sample latency.
  assign push      = inflight_q & ~(load & (count_q == '0));
  assign load_word = pop ? fifo_mem[rd_ptr_q] : bus.ocm_readdata;

  // Every word already committed (buffered, in flight or being unpacked)
  // counts, so a returning word always finds a free FIFO slot.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) + (CW + 1)'(hold_q);
  assign room      = (occupancy <= (CW + 1)'(FIFO_DEPTH));
  assign drained   = (count_q == '0) & ~inflight_q & (~hold_q | (fire & last_lane));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN: begin
        issue = room;
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: if (drained) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      nw_q       <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      lane_q     <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;

      if (state_q == S_IDLE && state_d == S_RUN) nw_q <= num_words;

      if (state_d == S_IDLE) ptr_q <= '0;
      else if (issue)        ptr_q <= (ptr_q == last_addr) ? '0 : ptr_q + ADDR_W'(1);

      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (load) begin
        shift_q <= load_word;
        lane_q  <= '0;
        hold_q  <= 1'b1;
      end else if (fire) begin
        shift_q <= shift_q >> SAMPLE_W;
        lane_q  <= lane_q + LW'(1);
        if (last_lane) hold_q <= 1'b0;
      end
    end
  end

  // Storage only; occupancy is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.ocm_readdata;
  end

  assign wrap_pulse         = issue & (ptr_q == last_addr);
  assign busy               = (state_q != S_IDLE);
  assign bus.ocm_address    = ptr_q;
  assign bus.ocm_chipselect = issue;
  assign bus.ocm_write      = 1'b0;
  assign bus.ocm_byteenable = '1;
  assign bus.ocm_clken      = reset;
  assign bus.noise_data     = shift_q[SAMPLE_W-1:0];
  assign bus.noise_valid    = hold_q;

endmodule

// File: tb/tb_ocm_noise_streamer.sv
// tb/tb_ocm_noise_streamer.sv - randomized self-checking bench for ocm_noise_streamer
module tb_ocm_noise_streamer;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int SAMPLE_W   = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int LANES      = DATA_W / SAMPLE_W;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [ADDR_W-1:0] num_words;
  logic              wrap_pulse;
  logic              busy;

  ocm_noise_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) bus ();

  ocm_noise_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .num_words(num_words),
    .wrap_pulse(wrap_pulse),
    .busy(busy),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  int eff = 1;
  int ready_mode = 0;

  int issue_cnt = 0;
  int samp_cnt  = 0;
  int wrap_cnt  = 0;
  int gap_cnt   = 0;
  bit seen_valid = 0;
  bit stall_q = 0;
  logic [SAMPLE_W-1:0] stall_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SAMPLE_W-1:0] model_sample(input int k);
    logic [DATA_W-1:0] w;
    w = mem[(k / LANES) % eff];
    return w[(k % LANES) * SAMPLE_W +: SAMPLE_W];
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h03020100 + 32'(i) * 32'h04040404;
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
  endtask

  task automatic sb_restart();
    issue_cnt = 0; samp_cnt = 0; wrap_cnt = 0; gap_cnt = 0;
    seen_valid = 0; stall_q = 0;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // OCM: one-cycle registered read; garbage when not selected.
  always @(posedge clk) begin
    if (bus.ocm_chipselect) bus.ocm_readdata <= mem[bus.ocm_address];
    else                    bus.ocm_readdata <= $urandom;
  end

  initial begin
    bus.noise_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.noise_ready = 1'b1;
        1:       bus.noise_ready = ~bus.noise_ready;
        2:       bus.noise_ready = 1'($urandom_range(0, 1));
        default: bus.noise_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: issue order, wrap marking, buffering bound, stall stability, sample order.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ocm_chipselect) begin
        check("addr", 32'(bus.ocm_address), 32'(issue_cnt % eff));
        check("wrap", 32'(wrap_pulse), 32'((issue_cnt % eff) == eff - 1));
        check("room", 32'((issue_cnt - samp_cnt / LANES) <= FIFO_DEPTH), 32'd1);
        if (wrap_pulse) wrap_cnt++;
        issue_cnt++;
      end else if (wrap_pulse) begin
        check("wrap_idle", 32'(wrap_pulse), 32'd0);
      end
      if (stall_q) begin
        check("stall_valid", 32'(bus.noise_valid), 32'd1);
        check("stall_data", 32'(bus.noise_data), 32'(stall_d));
      end
      if (bus.noise_valid && bus.noise_ready) begin
        check("sample", 32'(bus.noise_data), 32'(model_sample(samp_cnt)));
        samp_cnt++;
      end
      if (ready_mode == 0 && enable && seen_valid && !bus.noise_valid) gap_cnt++;
      if (bus.noise_valid) seen_valid = 1;
      stall_q = bus.noise_valid && !bus.noise_ready;
      stall_d = bus.noise_data;
    end
  end

  task automatic drain();
    int cyc;
    enable = 0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (busy && cyc < 300);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_words", 32'(samp_cnt), 32'(issue_cnt * LANES));
    check("drain_addr", 32'(bus.ocm_address), 32'd0);
    check("drain_valid", 32'(bus.noise_valid), 32'd0);
  endtask

  task automatic wait_first_valid();
    int lat;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.noise_valid && lat < 20);
    check("first_lat", 32'(lat), 32'd3);
  endtask

  task automatic run_samples(input int n);
    int cyc;
    cyc = 0;
    while (samp_cnt < n && cyc < n * 8 + 100) begin @(posedge clk); #1; cyc++; end
    check("progress", 32'(samp_cnt >= n), 32'd1);
    check("gaps", 32'(gap_cnt), 32'd0);
    check("wraps", 32'(wrap_cnt), 32'(issue_cnt / eff));
  endtask

  task automatic run_session(input logic [ADDR_W-1:0] nw, input int mode, input int n);
    num_words  = nw;
    ready_mode = mode;
    eff = (nw == 0) ? (1 << ADDR_W) : int'(nw);
    sb_restart();
    enable = 1;
    wait_first_valid();
    run_samples(n);
    drain();
  endtask

  initial begin
    int cyc;
    reset = 0; enable = 0; num_words = '0;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.noise_valid), 32'd0);
    check("rst_data", 32'(bus.noise_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(bus.ocm_chipselect), 32'd0);
    check("rst_addr", 32'(bus.ocm_address), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_clken", 32'(bus.ocm_clken), 32'd0);
    check("write_tie", 32'(bus.ocm_write), 32'd0);
    check("be_tie", 32'(bus.ocm_byteenable), 32'hF);
    reset = 1;
    @(posedge clk); #1;
    check("clken_run", 32'(bus.ocm_clken), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    run_session(10'd4, 0, 64);
    run_session(10'd4, 1, 64);
    run_session(10'd1, 0, 40);
    fill_random();
    run_session(10'd0, 0, 4100);
    fill_pattern();
    run_session(10'd4, 0, 6);
    run_session(10'd4, 0, 8);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_session(10'($urandom_range(1, 20)), 2, 120);
    end

    fill_pattern();
    num_words  = 10'd4;
    eff        = 4;
    ready_mode = 3;
    sb_restart();
    enable = 1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.noise_valid && cyc < 20);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.noise_valid), 32'd1);
    reset = 0;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(bus.noise_valid), 32'd0);
    check("mid_rst_cs", 32'(bus.ocm_chipselect), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(bus.noise_data), 32'd0);
    check("mid_rst_clken", 32'(bus.ocm_clken), 32'd0);
    @(posedge clk); #1;
    sb_restart();
    ready_mode = 2;
    reset = 1;
    wait_first_valid();
    run_samples(60);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
